// File: rtl/fp_accumulator_if.sv
// Handshake bundle between the FP32 multiplier stream and the accumulator.
// master = producer/consumer side, slave = accumulator side.
interface fp_accumulator_if;
    logic [31:0] data_in_0;
    logic        data_in_0_exception;
    logic        data_in_0_valid;
    logic        data_in_0_ready;
    logic [31:0] data_out_0;
    logic        data_out_0_invalid;
    logic        data_out_0_overflow;
    logic        data_out_0_valid;
    logic        data_out_0_ready;

    modport master (
        output data_in_0,
        output data_in_0_exception,
        output data_in_0_valid,
        input  data_in_0_ready,
        input  data_out_0,
        input  data_out_0_invalid,
        input  data_out_0_overflow,
        input  data_out_0_valid,
        output data_out_0_ready
    );

    modport slave (
        input  data_in_0,
        input  data_in_0_exception,
        input  data_in_0_valid,
        output data_in_0_ready,
        output data_out_0,
        output data_out_0_invalid,
        output data_out_0_overflow,
        output data_out_0_valid,
        input  data_out_0_ready
    );
endinterface

// File: rtl/fp_accumulator.sv
// Iterative FP32 reduction: sums VECTOR_LEN products per output,
// one element per 4 cycles, truncating, with sticky invalid/overflow.
module fp_accumulator #(
    parameter int VECTOR_LEN = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    fp_accumulator_if.slave bus
);

    localparam int CW = $clog2(VECTOR_LEN + 1);
    localparam logic [CW-1:0] LEN = CW'(VECTOR_LEN);

    typedef enum logic [2:0] {
        ACCEPT,
        ALIGN,
        ADD,
        NORM,
        OUTPUT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [31:0]   acc;
    logic [31:0]   opnd;
    logic [CW-1:0] cnt;
    logic          inv;
    logic          ovf;
    logic [23:0]   big_sig;
    logic [23:0]   small_sig;
    logic [7:0]    big_exp;
    logic          res_sign;
    logic          eff_sub;
    logic [24:0]   sum;

    logic          in_fire;
    logic          out_fire;
    logic          in_bad;

    logic          acc_big;
    logic [31:0]   b_op;
    logic [31:0]   s_op;
    logic [7:0]    diff;
    logic [23:0]   b_sig;
    logic [23:0]   s_sig;
    logic [23:0]   s_aln;

    logic [4:0]        lzc;
    logic [23:0]       shl;
    logic signed [9:0] exp_n;
    logic [22:0]       man_n;
    logic              sum_zero;

    assign in_fire  = (state == ACCEPT) && bus.data_in_0_valid;
    assign out_fire = (state == OUTPUT) && bus.data_out_0_ready;
    assign in_bad   = (bus.data_in_0[30:23] == 8'hFF)
                    || bus.data_in_0_exception;

    assign bus.data_in_0_ready     = (state == ACCEPT);
    assign bus.data_out_0_valid    = (state == OUTPUT);
    assign bus.data_out_0          = inv ? 32'd0 : acc;
    assign bus.data_out_0_invalid  = inv;
    assign bus.data_out_0_overflow = ovf;

    // Leading-zero count of a 24-bit significand (24 when all zero).
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd0;
        hit = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 5'd1;
            end
        end
        return n;
    endfunction

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ACCEPT;
        else        state <= state_nxt;
    end

    // Next-state decode; one cycle per processing step.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ACCEPT: if (bus.data_in_0_valid) state_nxt = ALIGN;
            ALIGN:  state_nxt = ADD;
            ADD:    state_nxt = NORM;
            NORM:   state_nxt = (cnt == LEN) ? OUTPUT : ACCEPT;
            OUTPUT: if (bus.data_out_0_ready) state_nxt = ACCEPT;
            default: state_nxt = ACCEPT;
        endcase
    end

    // Order operands by magnitude and align the smaller significand.
    always_comb begin
        acc_big = (acc[30:0] >= opnd[30:0]);
        b_op    = acc_big ? acc  : opnd;
        s_op    = acc_big ? opnd : acc;
        diff    = b_op[30:23] - s_op[30:23];
        b_sig   = (b_op[30:23] == 8'd0) ? 24'd0 : {1'b1, b_op[22:0]};
        s_sig   = (s_op[30:23] == 8'd0) ? 24'd0 : {1'b1, s_op[22:0]};
        s_aln   = (diff >= 8'd25) ? 24'd0 : (s_sig >> diff);
    end

    // Normalize the raw sum; exponent kept signed to catch underflow.
    always_comb begin
        lzc      = lzc24(sum[23:0]);
        shl      = sum[23:0] << lzc;
        sum_zero = (sum == 25'd0);
        exp_n    = 10'sd0;
        man_n    = 23'd0;
        if (sum[24]) begin
            exp_n = $signed({2'b00, big_exp}) + 10'sd1;
            man_n = sum[23:1];
        end else begin
            exp_n = $signed({2'b00, big_exp}) - $signed({5'b0, lzc});
            man_n = shl[22:0];
        end
    end

    // Datapath registers: operand latch, align, add, normalize, clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= 32'd0;
            opnd      <= 32'd0;
            cnt       <= '0;
            inv       <= 1'b0;
            ovf       <= 1'b0;
            big_sig   <= 24'd0;
            small_sig <= 24'd0;
            big_exp   <= 8'd0;
            res_sign  <= 1'b0;
            eff_sub   <= 1'b0;
            sum       <= 25'd0;
        end else begin
            unique case (state)
                ACCEPT: begin
                    if (in_fire) begin
                        cnt <= cnt + 1'b1;
                        if (in_bad) begin
                            inv  <= 1'b1;
                            opnd <= 32'd0;
                        end else if (bus.data_in_0[30:23] == 8'd0) begin
                            opnd <= 32'd0;
                        end else begin
                            opnd <= bus.data_in_0;
                        end
                    end
                end
                ALIGN: begin
                    big_sig   <= b_sig;
                    small_sig <= s_aln;
                    big_exp   <= b_op[30:23];
                    res_sign  <= b_op[31];
                    eff_sub   <= b_op[31] ^ s_op[31];
                end
                ADD: begin
                    if (eff_sub) sum <= {1'b0, big_sig} - {1'b0, small_sig};
                    else         sum <= {1'b0, big_sig} + {1'b0, small_sig};
                end
                NORM: begin
                    if (!ovf) begin
                        if (sum_zero || exp_n <= 10'sd0) begin
                            acc <= 32'd0;
                        end else if (exp_n >= 10'sd255) begin
                            acc <= {res_sign, 8'hFF, 23'd0};
                            ovf <= 1'b1;
                        end else begin
                            acc <= {res_sign, exp_n[7:0], man_n};
                        end
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        acc <= 32'd0;
                        cnt <= '0;
                        inv <= 1'b0;
                        ovf <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_accumulator.sv
// Directed-vector bench for fp_accumulator (VECTOR_LEN = 4).
// Expected sums are hand-computed FP32 constants.
module tb_fp_accumulator;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    fp_accumulator_if bus ();

    fp_accumulator #(
        .VECTOR_LEN(4)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Present one product at a negedge; returns at the negedge
    // right after the accepting posedge.
    task automatic send(input logic [31:0] d, input logic exc);
        int n;
        n = 0;
        while (!bus.data_in_0_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!bus.data_in_0_ready) check("send_timeout", 32'd0, 32'd1);
        bus.data_in_0           = d;
        bus.data_in_0_exception = exc;
        bus.data_in_0_valid     = 1'b1;
        @(negedge clk);
        bus.data_in_0_valid     = 1'b0;
        bus.data_in_0_exception = 1'b0;
        bus.data_in_0           = 32'd0;
    endtask

    // Wait for the sum, compare it, then complete the handshake.
    task automatic recv(
        input string       tag,
        input logic [31:0] d,
        input logic        iv,
        input logic        ov
    );
        int n;
        n = 0;
        while (!bus.data_out_0_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.data_out_0_valid), 32'd1);
        check({tag, "_data"}, bus.data_out_0, d);
        check({tag, "_inv"}, 32'(bus.data_out_0_invalid), 32'(iv));
        check({tag, "_ovf"}, 32'(bus.data_out_0_overflow), 32'(ov));
        bus.data_out_0_ready = 1'b1;
        @(negedge clk);
        bus.data_out_0_ready = 1'b0;
        check({tag, "_vld_drop"}, 32'(bus.data_out_0_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(bus.data_in_0_ready), 32'd1);
    endtask

    task automatic vec4(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] c,
        input logic [31:0] d
    );
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b0);
    endtask

    initial begin
        int          n;
        logic [31:0] held;
        n_chk  = 0;
        n_pass = 0;
        rst_n  = 1'b0;
        bus.data_in_0           = 32'd0;
        bus.data_in_0_exception = 1'b0;
        bus.data_in_0_valid     = 1'b0;
        bus.data_out_0_ready    = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ready", 32'(bus.data_in_0_ready), 32'd1);
        check("rst_valid", 32'(bus.data_out_0_valid), 32'd0);
        check("rst_data", bus.data_out_0, 32'd0);
        check("rst_inv", 32'(bus.data_out_0_invalid), 32'd0);
        check("rst_ovf", 32'(bus.data_out_0_overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1+2+3+4 = 10, latency from the last handshake.
        vec4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        check("lat_align", 32'(bus.data_out_0_valid), 32'd0);
        check("lat_busy", 32'(bus.data_in_0_ready), 32'd0);
        n = 0;
        while (!bus.data_out_0_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", 32'(n), 32'd3);
        recv("sum10", 32'h41200000, 1'b0, 1'b0);

        vec4(32'h3FC00000, 32'hBFC00000, 32'h0, 32'h0);
        recv("cancel", 32'h00000000, 1'b0, 1'b0);

        vec4(32'h3F800000, 32'h33800000, 32'h0, 32'h0);
        recv("trunc", 32'h3F800000, 1'b0, 1'b0);

        vec4(32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h0);
        recv("ovf", 32'h7F800000, 1'b0, 1'b1);

        // 1.5 - 4 = -2.5
        vec4(32'h3FC00000, 32'hC0800000, 32'h0, 32'h0);
        recv("neg", 32'hC0200000, 1'b0, 1'b0);

        send(32'h3F800000, 1'b0);
        send(32'h00000000, 1'b1);
        send(32'h0, 1'b0);
        send(32'h0, 1'b0);
        recv("inv", 32'h00000000, 1'b1, 1'b0);

        vec4(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000);
        recv("clean", 32'h41200000, 1'b0, 1'b0);

        // Back-pressure: 5 stalled cycles with stable output.
        vec4(32'h40000000, 32'h40000000, 32'h40000000, 32'h0);
        n = 0;
        while (!bus.data_out_0_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = bus.data_out_0;
        check("bp_first", held, 32'h40C00000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_data", bus.data_out_0, 32'h40C00000);
            check("bp_valid", 32'(bus.data_out_0_valid), 32'd1);
            check("bp_inrdy", 32'(bus.data_in_0_ready), 32'd0);
            check("bp_flags",
                  32'({bus.data_out_0_invalid, bus.data_out_0_overflow}),
                  32'd0);
        end
        bus.data_out_0_ready = 1'b1;
        @(negedge clk);
        bus.data_out_0_ready = 1'b0;
        check("bp_rel_inrdy", 32'(bus.data_in_0_ready), 32'd1);
        bus.data_in_0       = 32'h3F800000;
        bus.data_in_0_valid = 1'b1;
        @(negedge clk);
        bus.data_in_0_valid = 1'b0;
        bus.data_in_0       = 32'd0;
        check("bp_accepted", 32'(bus.data_in_0_ready), 32'd0);
        send(32'h3F800000, 1'b0);
        send(32'h0, 1'b0);
        send(32'h0, 1'b0);
        recv("bp_next", 32'h40000000, 1'b0, 1'b0);

        // Reset after two elements of a vector.
        send(32'h40400000, 1'b1);
        send(32'h40400000, 1'b0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 32'(bus.data_in_0_ready), 32'd1);
        check("mid_rst_valid", 32'(bus.data_out_0_valid), 32'd0);
        check("mid_rst_data", bus.data_out_0, 32'd0);
        check("mid_rst_inv", 32'(bus.data_out_0_invalid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vec4(32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000);
        recv("after_rst", 32'h41000000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fp_accumulator.md
# fp_accumulator

Sequential FP32 reduction stage that sits directly downstream of the FP32 multiplier. It consumes a stream of products over a valid/ready handshake and sums each group of `VECTOR_LEN` products with an iterative multi-cycle adder. It then emits one FP32 sum with sticky invalid/overflow flags. Together with the multiplier it forms the dot-product datapath.

## Interface
- `VECTOR_LEN`, default 4: products per sum; must be ≥1.
- `clk`  in  1: clock, rising edge.
- `rst_n`  in  1: asynchronous active-low reset.
- `data_in_0`  in  32: FP32 product.
- `data_in_0_exception`  in  1: multiplier Exception flag for this product.
- `data_in_0_valid`  in  1: product valid.
- `data_in_0_ready`  out  1: accepting a product.
- `data_out_0`  out  32: FP32 sum.
- `data_out_0_invalid`  out  1: sticky flag; any element in the vector was an exception.
- `data_out_0_overflow`  out  1: sticky flag; the accumulator saturated to ±inf.
- `data_out_0_valid`  out  1: sum valid.
- `data_out_0_ready`  in  1: downstream accepts the sum.

## Operation
- FSM states:
  - ACCEPT: `data_in_0_ready`=1. On valid, latch the operand and go to ALIGN.
  - ALIGN → ADD → NORM: fixed, one cycle each.
  - NORM → ACCEPT if count < `VECTOR_LEN`, else NORM → OUTPUT.
  - OUTPUT: `data_out_0_valid`=1. On `data_out_0_ready`, clear the accumulator, count and flags, then go to ACCEPT.
- Accumulator state:
  - Starts at +0.
  - Element count is `$clog2(VECTOR_LEN+1)` bits and increments on each accepted product.
- Operand decode:
  - exp==0 → treated as zero; denormals flushed.
  - exp==255 or `data_in_0_exception`=1 → sets invalid and contributes zero.
- Align:
  - Order the two operands by magnitude, comparing {exp, mantissa}.
  - Shift the smaller 24-bit significand (hidden bit included) right by the exponent difference; shifted-out bits are discarded.
  - Difference ≥25 → smaller operand becomes 0.
- Add: 25-bit add if signs are equal, otherwise subtract smaller from larger. Result sign is the larger operand's sign.
- Normalize:
  - Bit24 set → shift right 1, exp+1.
  - Otherwise → shift left by leading-zero count (combinational LZC), exp − LZC.
  - Zero significand → +0.
  - Final exp ≤0 → +0 (flush).
  - Final exp ≥255 → ±inf (exp 8'hFF, mantissa 0) and overflow set.
- Rounding: truncation (round toward zero) everywhere.
- Saturation: once overflow is set, the accumulator holds ±inf for the rest of the vector; further adds are ignored.
- Output encoding: invalid=1 → `data_out_0` = 32'd0, with both flags still reported. Otherwise `data_out_0` = accumulator.

## Timing
- Reset values: state ACCEPT, `data_in_0_ready`=1, `data_out_0`=0, `data_out_0_valid`=0, both flags 0, count 0, accumulator +0.
- Per element: 1 accept cycle + 3 processing cycles, so at most one product every 4 cycles.
- Sum latency: `data_out_0_valid` rises 4 cycles after the handshake of the last element, in the cycle after its NORM.
- `data_in_0_ready`=0 in ALIGN/ADD/NORM/OUTPUT. There is no overlap between vectors.
- While `data_out_0_valid`=1 and `data_out_0_ready`=0, `data_out_0` and both flags are held stable.
- Output handshake in cycle t → `data_out_0_valid`=0 and `data_in_0_ready`=1 in cycle t+1.
- Minimum period per vector: 4·`VECTOR_LEN`+1 cycles.
- Reset mid-operation: `rst_n` low at any state aborts the partial sum, and all outputs take reset values immediately.
- All outputs are registered or decoded from registered state. There are no combinational input→output paths.

## Test plan
- **Basic sum:** `VECTOR_LEN`=4, inputs 3F800000, 40000000, 40400000, 40800000 with no stalls → `data_out_0`=41200000 (10.0). valid rises 4 cycles after the 4th handshake; flags 0.
- **Cancellation and truncation:**
  - Inputs 3FC00000, BFC00000, 00000000, 00000000 → 00000000.
  - Inputs 3F800000, 33800000, 0, 0 → 3F800000 (2^-24 truncated).
- **Overflow:** inputs 7F7FFFFF, 7F7FFFFF, 0, 0 → 7F800000 with overflow=1, invalid=0.
- **Invalid:** input 3F800000, then 00000000 with `data_in_0_exception`=1, then 0, 0 → `data_out_0`=00000000, invalid=1. A following clean vector reports invalid=0.
- **Back-pressure:** hold `data_out_0_ready`=0 for 5 cycles after valid rises → output and flags stay constant and `data_in_0_ready`=0. Releasing ready → the next vector is accepted the following cycle.
- **Reset mid-vector:** assert `rst_n`=0 after 2 of 4 elements → outputs take reset values immediately. A fresh vector 40000000 ×4 then yields 41000000.
